// File: rtl/uart_dump_pkg.sv
// ---------------------------------------------------------------------------
// uart_dump_pkg
//   Shared types for the BRAM-to-UART dump logic.
//
//   dump_state_t : sequencer state of bram_uart_dumper. A byte is read
//                  from BRAM (READ/WAIT_DATA, twice per byte for nibble
//                  memories), handed to the UART (SEND), and the
//                  transmitter's busy flag is followed through one full
//                  high/low cycle (WAIT_HI/WAIT_LO) before the next byte.
// ---------------------------------------------------------------------------
package uart_dump_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        WAIT_DATA = 3'd2,
        SEND      = 3'd3,
        WAIT_HI   = 3'd4,
        WAIT_LO   = 3'd5,
        DONE      = 3'd6
    } dump_state_t;

endpackage : uart_dump_pkg

// File: rtl/bram_uart_dumper.sv
// ---------------------------------------------------------------------------
// bram_uart_dumper
//   Streams a run of bytes out of a read-latency BRAM into a byte-wide UART
//   transmitter, one byte in flight at a time.
//
//   Parameters
//     BRAM_WIDTH   : 8 (one word per byte) or 4 (two nibbles per byte,
//                    low nibble first)
//     BRAM_DEPTH   : number of BRAM words; read address wraps modulo this
//     READ_LATENCY : cycles from addr_out to valid bram_data_in (>= 1)
//
//   Ports
//     clk_in          system clock
//     rst_in          synchronous, active-high reset
//     start_in        one-cycle dump request, honoured only while idle
//     base_addr_in    first word address, sampled on an accepted start
//     len_in          byte count (0 .. 2^ADDR_WIDTH), sampled on start
//     addr_out        BRAM read address
//     bram_data_in    BRAM read data
//     tx_data_out     byte to the UART, stable from trigger until busy falls
//     tx_trigger_out  one-cycle send pulse to the UART
//     tx_busy_in      UART busy flag
//     busy_out        high from an accepted start until done_out
//     done_out        one-cycle pulse when the dump (possibly empty) ends
// ---------------------------------------------------------------------------
module bram_uart_dumper
    import uart_dump_pkg::*;
#(
    parameter  int BRAM_WIDTH   = 8,
    parameter  int BRAM_DEPTH   = 40_000,
    parameter  int READ_LATENCY = 2,
    localparam int ADDR_WIDTH   = $clog2(BRAM_DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH-1:0] base_addr_in,
    input  logic [ADDR_WIDTH:0]   len_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [BRAM_WIDTH-1:0] bram_data_in,
    output logic [7:0]            tx_data_out,
    output logic                  tx_trigger_out,
    input  logic                  tx_busy_in,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(BRAM_DEPTH - 1);
    localparam logic [LAT_W-1:0]      LAT_LAST    = LAT_W'(READ_LATENCY);
    localparam bit                    NIBBLE_MODE = (BRAM_WIDTH == 4);

    dump_state_t           state;
    logic [CNT_W-1:0]      bytes_left;   // bytes still to complete, incl. current
    logic [LAT_W-1:0]      lat_cnt;      // cycles elapsed since READ
    logic [7:0]            byte_buf;     // byte being assembled from BRAM
    logic                  hi_nibble;    // next nibble capture fills byte_buf[7:4]
    logic [7:0]            data_ext;
    logic [ADDR_WIDTH-1:0] addr_next;

    // Zero-extend so both word widths share one byte-wide capture path.
    assign data_ext = 8'(bram_data_in);

    // Explicit compare-and-wrap: the depth need not be a power of two, so
    // letting the adder overflow would walk off the end of the memory.
    assign addr_next = (addr_out == LAST_ADDR) ? '0 : addr_out + ADDR_WIDTH'(1);

    // NOTE: every register here, outputs included, is updated with
    // non-blocking assignments so that all reads in this block see the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            addr_out       <= '0;
            tx_data_out    <= '0;
            tx_trigger_out <= 1'b0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            bytes_left     <= '0;
            lat_cnt        <= '0;
            byte_buf       <= '0;
            hi_nibble      <= 1'b0;
        end else begin
            // Pulse outputs default low; only SEND and DONE raise them.
            tx_trigger_out <= 1'b0;
            done_out       <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_in) begin
                        addr_out   <= base_addr_in;
                        bytes_left <= len_in;
                        hi_nibble  <= 1'b0;
                        busy_out   <= 1'b1;
                        state      <= (len_in == '0) ? DONE : READ;
                    end
                end

                // Address is already on addr_out; just start the latency count.
                READ: begin
                    lat_cnt <= LAT_W'(1);
                    state   <= WAIT_DATA;
                end

                WAIT_DATA: begin
                    if (lat_cnt == LAT_LAST) begin
                        addr_out <= addr_next;
                        if (NIBBLE_MODE && !hi_nibble) begin
                            // Low half only: go back for the second word.
                            byte_buf[3:0] <= data_ext[3:0];
                            hi_nibble     <= 1'b1;
                            state         <= READ;
                        end else if (NIBBLE_MODE) begin
                            byte_buf[7:4] <= data_ext[3:0];
                            hi_nibble     <= 1'b0;
                            state         <= SEND;
                        end else begin
                            byte_buf <= data_ext;
                            state    <= SEND;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                // Stall here while the transmitter is still busy.
                SEND: begin
                    if (!tx_busy_in) begin
                        tx_data_out    <= byte_buf;
                        tx_trigger_out <= 1'b1;
                        state          <= WAIT_HI;
                    end
                end

                // Wait for the transmitter to acknowledge by raising busy,
                // so a slow busy flag can't be mistaken for completion.
                WAIT_HI: begin
                    if (tx_busy_in) begin
                        state <= WAIT_LO;
                    end
                end

                WAIT_LO: begin
                    if (!tx_busy_in) begin
                        bytes_left <= bytes_left - CNT_W'(1);
                        state      <= (bytes_left == CNT_W'(1)) ? DONE : READ;
                    end
                end

                // start_in is deliberately not looked at in this state.
                DONE: begin
                    done_out <= 1'b1;
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : bram_uart_dumper

// File: doc/bram_uart_dumper.md
BRAM_UART_DUMPER -- requirements
Module: bram_uart_dumper

Interface
REQ-001 The module SHALL have parameter BRAM_WIDTH, default 8: word width of the source BRAM; legal values 8 (one word per byte) or 4 (two nibbles per byte).
REQ-002 The module SHALL have parameter BRAM_DEPTH, default 40_000: number of BRAM words; the address space wraps at this value.
REQ-003 The module SHALL have parameter READ_LATENCY, default 2: cycles from addr_out to valid bram_data_in, matching the output-registered BRAM.
REQ-004 The module SHALL have localparam ADDR_WIDTH = $clog2(BRAM_DEPTH).
REQ-005 The module SHALL have port clk_in  input  1: the single system clock.
REQ-006 The module SHALL have port rst_in  input  1: reset, synchronous and active-high.
REQ-007 The module SHALL have port start_in  input  1: a one-cycle request to begin a dump.
REQ-008 The module SHALL have port base_addr_in  input  ADDR_WIDTH: first BRAM word to read, sampled when start is accepted.
REQ-009 The module SHALL have port len_in  input  ADDR_WIDTH+1: number of bytes to transmit, sampled when start is accepted.
REQ-010 The module SHALL have port addr_out  output  ADDR_WIDTH: BRAM port-A read address.
REQ-011 The module SHALL have port bram_data_in  input  BRAM_WIDTH: BRAM port-A read data.
REQ-012 The module SHALL have port tx_data_out  output  8: byte to the UART transmitter, held stable from trigger until busy falls.
REQ-013 The module SHALL have port tx_trigger_out  output  1: a one-cycle send pulse to the UART transmitter.
REQ-014 The module SHALL have port tx_busy_in  input  1: UART transmitter busy flag.
REQ-015 The module SHALL have port busy_out  output  1: high from start acceptance until done_out.
REQ-016 The module SHALL have port done_out  output  1: a one-cycle pulse after the last byte completes, or for a zero-length dump.

Function
REQ-017 The state machine SHALL have the states IDLE, READ, WAIT_DATA, SEND, WAIT_HI, WAIT_LO and DONE.
REQ-018 In IDLE, start_in=1 SHALL latch base and length, drive addr_out=base and set busy_out the next cycle; if len_in=0, the FSM SHALL go to DONE instead.
REQ-019 A start_in pulse received while busy_out=1 SHALL be ignored without effect.
REQ-020 READ SHALL hold addr_out; WAIT_DATA SHALL count READ_LATENCY cycles and then capture bram_data_in.
REQ-021 When BRAM_WIDTH=8, each captured word SHALL be one byte.
REQ-022 When BRAM_WIDTH=4, the first captured nibble SHALL be byte[3:0] and the second byte[7:4], requiring two READ/WAIT_DATA passes per byte.
REQ-023 The word address SHALL increment by one after each capture and wrap from BRAM_DEPTH-1 to 0 (modulo BRAM_DEPTH, never by power-of-two truncation).
REQ-024 SEND SHALL enter only when tx_busy_in=0, pulse tx_trigger_out for exactly one cycle, and then go to WAIT_HI; while tx_busy_in=1, SEND SHALL stall.
REQ-025 WAIT_HI SHALL wait for tx_busy_in=1; WAIT_LO SHALL then wait for tx_busy_in=0.
REQ-026 After WAIT_LO, the byte counter SHALL decrement; if it reaches 0 the FSM SHALL go to DONE, otherwise to READ.
REQ-027 DONE SHALL pulse done_out for one cycle, clear busy_out, and return to IDLE; a start_in in the DONE cycle SHALL be ignored.
REQ-028 Only one byte SHALL be in flight at a time, and tx_trigger_out SHALL never assert while tx_busy_in=1.
REQ-029 len_in=2^ADDR_WIDTH SHALL be legal and SHALL wrap the read address.

Reset
REQ-030 When rst_in=1 on a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0: addr_out, tx_data_out, tx_trigger_out, busy_out, done_out.
REQ-031 Reset mid-dump SHALL abort the dump immediately with no done_out; a byte already handed to the transmitter is the transmitter's concern.
REQ-032 Reset SHALL take priority over start_in in the same cycle.

Structure
REQ-033 The state enum typedef SHALL reside in the shared package uart_dump_pkg; parameters SHALL remain module-local.
REQ-034 The module SHALL be self-contained, with the address/byte counters and nibble packer inline and no sub-module.

Verification
REQ-035 With BRAM_WIDTH=8, BRAM[10..12]=0x41,0x42,0x43, start with base=10, len=3, and a UART model whose busy rises 1 cycle after trigger for 20 cycles: the bench SHALL see tx bytes 0x41,0x42,0x43 in order, 3 triggers, and done_out once.
REQ-036 With BRAM_WIDTH=4, BRAM[0..3]=0x1,0x2,0x3,0x4 and len=2: the bench SHALL see bytes 0x21 then 0x43.
REQ-037 With base=39_999 and len=2 at depth 40_000: the bench SHALL see reads at addresses 39_999 then 0.
REQ-038 With len=0: done_out SHALL pulse 2 cycles after start, with no tx_trigger_out.
REQ-039 With tx_busy_in held high for 50 cycles before the first trigger: no trigger SHALL occur until busy falls, and a second start mid-dump SHALL be ignored.
REQ-040 rst_in asserted during WAIT_LO of byte 2 of 5: the bench SHALL see outputs return to 0 the next cycle, no done_out, and a fresh start working normally.
